// File: rtl/tdm_demux4_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux4_pkg
//   Shared definitions for the 4-channel TDM mux/demux pair: FSM state
//   encodings, the channel count and the slot-index width. The matching 4:1
//   mux transmitter imports the same package, so both ends agree on slot order.
// -----------------------------------------------------------------------------
package tdm_demux4_pkg;

    // Number of channels carried in one frame.
    localparam int N_CH  = 4;

    // Width of the slot index (log2 of N_CH).
    localparam int SEL_W = 2;

    // Index of the last slot in a frame. The beat in this slot completes the frame.
    localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_CH - 1);

    // Receiver framing state.
    typedef enum logic {
        ST_HUNT = 1'b0,   // waiting for a start-of-frame beat
        ST_LOCK = 1'b1    // aligned; slots are steered by sel
    } state_e;

endpackage : tdm_demux4_pkg

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//   Receive-side time-division demultiplexer. A 4:1 mux sends slots in channel
//   order 0,1,2,3. Each frame starts with a start-of-frame beat on slot 0. This
//   block steers each accepted slot into a staging register. When the slot-3
//   beat arrives, it publishes the whole frame on out_ch0..3 and pulses
//   out_valid for one cycle.
//   If the framing breaks, the block pulses sync_err for one cycle. A late
//   start-of-frame restarts the frame. A missing start-of-frame sends the
//   block back to hunting.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   beat qualifier; no beat when low (stall)
//   in_sof     start of frame, meaningful only with in_valid
//   in_data    slot payload, W bits
//   out_valid  one-cycle pulse: a new frame is on out_ch0..3
//   out_ch0..3 channel words of the last completed frame (held between frames)
//   sel        slot index expected on the next beat
//   locked     high while in LOCK
//   sync_err   one-cycle pulse after a framing violation
//   frame_cnt  completed-frame count, wraps 255 -> 0
//
// All outputs come straight from registers, so no input-to-output
// combinational path exists.
// -----------------------------------------------------------------------------
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    output logic [W-1:0]     out_ch0,
    output logic [W-1:0]     out_ch1,
    output logic [W-1:0]     out_ch2,
    output logic [W-1:0]     out_ch3,
    output logic [SEL_W-1:0] sel,
    output logic             locked,
    output logic             sync_err,
    output logic [7:0]       frame_cnt
);

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [W-1:0]     stage0_q, stage1_q, stage2_q;
    logic [W-1:0]     ch0_q, ch1_q, ch2_q, ch3_q;
    logic             out_valid_q;
    logic             sync_err_q;
    logic [7:0]       frame_cnt_q;

    // NOTE: every register in this block uses non-blocking assignment. All
    // right-hand sides therefore see the pre-edge values. The slot-3 beat
    // relies on this when it copies the staging registers to the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the staging registers are reset together with the control
            // state, so no stale slot from before reset can ever be observed.
            state_q     <= ST_HUNT;
            sel_q       <= '0;
            stage0_q    <= '0;
            stage1_q    <= '0;
            stage2_q    <= '0;
            ch0_q       <= '0;
            ch1_q       <= '0;
            ch2_q       <= '0;
            ch3_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // out_valid and sync_err are single-cycle pulses.
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;

            if (in_valid) begin
                case (state_q)
                    ST_HUNT: begin
                        // Only a start-of-frame beat can establish alignment.
                        if (in_sof) begin
                            stage0_q <= in_data;
                            sel_q    <= SEL_W'(1);
                            state_q  <= ST_LOCK;
                        end
                    end

                    ST_LOCK: begin
                        if (in_sof && (sel_q != '0)) begin
                            // Early start of frame: drop the partial frame
                            // and restart the frame with this beat as slot 0.
                            stage0_q   <= in_data;
                            sel_q      <= SEL_W'(1);
                            sync_err_q <= 1'b1;
                        end else if (!in_sof && (sel_q == '0)) begin
                            // Missing start of frame: alignment is lost.
                            sel_q      <= '0;
                            state_q    <= ST_HUNT;
                            sync_err_q <= 1'b1;
                        end else begin
                            case (sel_q)
                                SEL_W'(0): stage0_q <= in_data;
                                SEL_W'(1): stage1_q <= in_data;
                                SEL_W'(2): stage2_q <= in_data;
                                default:   ;  // slot 3 goes straight to out_ch3
                            endcase

                            if (sel_q == SLOT_LAST) begin
                                ch0_q       <= stage0_q;
                                ch1_q       <= stage1_q;
                                ch2_q       <= stage2_q;
                                ch3_q       <= in_data;
                                out_valid_q <= 1'b1;
                                frame_cnt_q <= frame_cnt_q + 8'd1;
                            end

                            // Wraps 3 -> 0 because the index is exactly 2 bits wide.
                            sel_q <= sel_q + SEL_W'(1);
                        end
                    end

                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch0   = ch0_q;
    assign out_ch1   = ch1_q;
    assign out_ch2   = ch2_q;
    assign out_ch3   = ch3_q;
    assign sel       = sel_q;
    assign locked    = (state_q == ST_LOCK);
    assign sync_err  = sync_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4
//   Directed, self-checking bench for tdm_demux4. Inputs change on the falling
//   edge, and outputs are checked 1 ns after the rising edge that samples them.
//   Pulse monitors on the falling edge count out_valid and sync_err pulses.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_ch0, out_ch1, out_ch2, out_ch3;
    logic [1:0] sel;
    logic       locked;
    logic       sync_err;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int ov_count = 0;
    int se_count = 0;

    tdm_demux4 #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ch0   (out_ch0),
        .out_ch1   (out_ch1),
        .out_ch2   (out_ch2),
        .out_ch3   (out_ch3),
        .sel       (sel),
        .locked    (locked),
        .sync_err  (sync_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) ov_count++;
        if (sync_err === 1'b1)  se_count++;
    end

    // Time limit on the run.
    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic sof, input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_sof = sof; in_data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, b, c, d);
        beat(1'b1, a); beat(1'b0, b); beat(1'b0, c); beat(1'b0, d);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, sync_err, locked, sel, frame_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%0b err=%0b locked=%0b sel=%0d cnt=%0d, exp all 0",
                     out_valid, sync_err, locked, sel, frame_cnt);
        end
        checks++;
        if ({out_ch0, out_ch1, out_ch2, out_ch3} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h, exp 00 00 00 00",
                     out_ch0, out_ch1, out_ch2, out_ch3);
        end
    endtask

    task automatic test_basic_frame();
        int ov0 = ov_count;
        int se0 = se_count;
        beat(1'b1, 8'hA1);
        checks++;
        if (locked !== 1'b1 || sel !== 2'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_slot0: got locked=%0b sel=%0d valid=%0b, exp 1 1 0", locked, sel, out_valid);
        end
        beat(1'b0, 8'hB2); beat(1'b0, 8'hC3);
        checks++;
        if (out_valid !== 1'b0 || out_ch0 !== 8'h00) begin
            errors++;
            $display("FAIL basic_partial: got valid=%0b ch0=%h, exp 0 00", out_valid, out_ch0);
        end
        beat(1'b0, 8'hD4);
        checks++;
        if (out_valid !== 1'b1 || {out_ch0, out_ch1, out_ch2, out_ch3} !== 32'hA1B2C3D4) begin
            errors++;
            $display("FAIL basic_out: got valid=%0b ch=%h%h%h%h, exp 1 A1B2C3D4",
                     out_valid, out_ch0, out_ch1, out_ch2, out_ch3);
        end
        checks++;
        if (frame_cnt !== 8'd1 || locked !== 1'b1 || sel !== 2'd0) begin
            errors++;
            $display("FAIL basic_state: got cnt=%0d locked=%0b sel=%0d, exp 1 1 0", frame_cnt, locked, sel);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || out_ch3 !== 8'hD4) begin
            errors++;
            $display("FAIL basic_pulse_hold: got valid=%0b ch3=%h, exp 0 D4", out_valid, out_ch3);
        end
        checks++;
        if (ov_count - ov0 !== 1 || se_count - se0 !== 0) begin
            errors++;
            $display("FAIL basic_counts: got ov=%0d se=%0d, exp 1 0", ov_count - ov0, se_count - se0);
        end
    endtask

    task automatic test_stall();
        beat(1'b1, 8'hA1); beat(1'b0, 8'hB2);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            checks++;
            if (sel !== 2'd2 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got sel=%0d valid=%0b, exp 2 0", i, sel, out_valid);
            end
        end
        beat(1'b0, 8'hC3); beat(1'b0, 8'hD4);
        checks++;
        if (out_valid !== 1'b1 || {out_ch0, out_ch1, out_ch2, out_ch3} !== 32'hA1B2C3D4 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL stall_out: got valid=%0b ch=%h%h%h%h cnt=%0d, exp 1 A1B2C3D4 2",
                     out_valid, out_ch0, out_ch1, out_ch2, out_ch3, frame_cnt);
        end
        idle(1);
    endtask

    task automatic test_hunt();
        int ov0;
        int se0;
        do_reset();
        ov0 = ov_count;
        se0 = se_count;
        beat(1'b0, 8'h11); beat(1'b0, 8'h22);
        checks++;
        if (locked !== 1'b0 || sel !== 2'd0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL hunt_discard: got locked=%0b sel=%0d err=%0b, exp 0 0 0", locked, sel, sync_err);
        end
        send_frame(8'h01, 8'h02, 8'h03, 8'h04);
        checks++;
        if ({out_ch0, out_ch1, out_ch2, out_ch3} !== 32'h01020304 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL hunt_out: got ch=%h%h%h%h cnt=%0d, exp 01020304 1",
                     out_ch0, out_ch1, out_ch2, out_ch3, frame_cnt);
        end
        idle(1);
        checks++;
        if (ov_count - ov0 !== 1 || se_count - se0 !== 0) begin
            errors++;
            $display("FAIL hunt_counts: got ov=%0d se=%0d, exp 1 0", ov_count - ov0, se_count - se0);
        end
    endtask

    task automatic test_resync();
        int ov0 = ov_count;
        int se0 = se_count;
        beat(1'b1, 8'h10); beat(1'b0, 8'h20);
        beat(1'b1, 8'h30);
        checks++;
        if (sync_err !== 1'b1 || sel !== 2'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL resync_err: got err=%0b sel=%0d locked=%0b, exp 1 1 1", sync_err, sel, locked);
        end
        beat(1'b0, 8'h40);
        checks++;
        if (sync_err !== 1'b0 || out_ch0 !== 8'h01) begin
            errors++;
            $display("FAIL resync_pulse: got err=%0b ch0=%h, exp 0 01", sync_err, out_ch0);
        end
        beat(1'b0, 8'h50); beat(1'b0, 8'h60);
        checks++;
        if (out_valid !== 1'b1 || {out_ch0, out_ch1, out_ch2, out_ch3} !== 32'h30405060 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL resync_out: got valid=%0b ch=%h%h%h%h cnt=%0d, exp 1 30405060 2",
                     out_valid, out_ch0, out_ch1, out_ch2, out_ch3, frame_cnt);
        end
        idle(1);
        checks++;
        if (ov_count - ov0 !== 1 || se_count - se0 !== 1) begin
            errors++;
            $display("FAIL resync_counts: got ov=%0d se=%0d, exp 1 1", ov_count - ov0, se_count - se0);
        end
    endtask

    task automatic test_lost_sync_and_reset();
        beat(1'b0, 8'h77);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || sel !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lost_err: got err=%0b locked=%0b sel=%0d valid=%0b, exp 1 0 0 0",
                     sync_err, locked, sel, out_valid);
        end
        checks++;
        if ({out_ch0, out_ch1, out_ch2, out_ch3} !== 32'h30405060 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL lost_hold: got ch=%h%h%h%h cnt=%0d, exp 30405060 2",
                     out_ch0, out_ch1, out_ch2, out_ch3, frame_cnt);
        end
        idle(1);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL lost_pulse: got err=%0b, exp 0", sync_err);
        end
        // Reset mid-frame, with a beat presented in the same cycle.
        beat(1'b1, 8'h81); beat(1'b0, 8'h82);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h83;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, sync_err, locked, sel, frame_cnt} !== 13'd0 || out_ch0 !== 8'h00) begin
            errors++;
            $display("FAIL midrst: got valid=%0b err=%0b locked=%0b sel=%0d cnt=%0d ch0=%h, exp all 0",
                     out_valid, sync_err, locked, sel, frame_cnt, out_ch0);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        send_frame(8'h91, 8'h92, 8'h93, 8'h94);
        checks++;
        if (frame_cnt !== 8'd1 || {out_ch0, out_ch1, out_ch2, out_ch3} !== 32'h91929394) begin
            errors++;
            $display("FAIL midrst_frame: got cnt=%0d ch=%h%h%h%h, exp 1 91929394",
                     frame_cnt, out_ch0, out_ch1, out_ch2, out_ch3);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int ov0;
        logic [7:0] base;
        do_reset();
        ov0 = ov_count;
        for (int f = 0; f < 256; f++) begin
            base = 8'(f);
            send_frame(base, base ^ 8'h55, base ^ 8'hAA, ~base);
            if (f == 254) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL b2b_255: got cnt=%0d, exp 255", frame_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 8'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wrap: got cnt=%0d valid=%0b, exp 0 1", frame_cnt, out_valid);
        end
        checks++;
        if ({out_ch0, out_ch1, out_ch2, out_ch3} !== 32'hFFAA5500) begin
            errors++;
            $display("FAIL b2b_last: got ch=%h%h%h%h, exp FFAA5500", out_ch0, out_ch1, out_ch2, out_ch3);
        end
        idle(1);
        checks++;
        if (ov_count - ov0 !== 256) begin
            errors++;
            $display("FAIL b2b_count: got ov=%0d, exp 256", ov_count - ov0);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
        test_reset();
        test_basic_frame();
        test_stall();
        test_hunt();
        test_resync();
        test_lost_sync_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tdm_demux4
